// File: rtl/cnt_chk_pkg.sv
// Shared types and default widths for the counter sequence checker.
package cnt_chk_pkg;

  typedef enum logic [1:0] {
    CHK_ACQ,
    CHK_SYNC,
    CHK_LOCK
  } chk_state_e;

  localparam int unsigned CNT_W_DEF  = 3;
  localparam int unsigned WRAP_W_DEF = 8;
  localparam int unsigned ERR_W_DEF  = 8;

endpackage

// File: rtl/cnt_chk_sat_ctr.sv
// Saturating up-counter; clr together with inc loads 1 (restart a run at one).
module cnt_chk_sat_ctr #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = inc ? WIDTH'(1) : '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/cnt_seq_checker.sv
// Checks that a wrap-around counter stream advances by +1 per valid sample; locks, counts wraps/errors.
// Optional sticky error flag port err_sticky when CNT_CHK_STICKY_ERR_EN is defined.
module cnt_seq_checker
  import cnt_chk_pkg::*;
#(
  parameter int unsigned W        = CNT_W_DEF,
  parameter int unsigned WRAP_W   = WRAP_W_DEF,
  parameter int unsigned ERR_W    = ERR_W_DEF,
  parameter int unsigned LOCK_N   = 4,
  parameter int unsigned UNLOCK_N = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              cnt_vld,
  input  logic [W-1:0]      cnt_val,
`ifdef CNT_CHK_STICKY_ERR_EN
  output logic              err_sticky,
`endif
  output logic              locked,
  output logic [W-1:0]      exp_val,
  output logic              wrap_pulse,
  output logic              err_pulse,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic [ERR_W-1:0]  err_cnt
);

  localparam int unsigned GOOD_W = $clog2(LOCK_N + 1);
  localparam int unsigned BAD_W  = $clog2(UNLOCK_N + 1);

  chk_state_e        state_q, state_d;
  logic              locked_q, locked_d;
  logic [W-1:0]      exp_q, exp_d;
  logic              wrap_pulse_q, wrap_pulse_d;
  logic              err_pulse_q, err_pulse_d;
  logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;
  logic [GOOD_W-1:0] good_cnt;
  logic [BAD_W-1:0]  bad_cnt;
  logic              good_clr, good_inc, bad_clr, bad_inc, err_inc;
  logic              match;

  assign match = (cnt_val == exp_q);

  always_comb begin
    state_d      = state_q;
    locked_d     = locked_q;
    exp_d        = exp_q;
    wrap_pulse_d = 1'b0;
    err_pulse_d  = 1'b0;
    wrap_cnt_d   = wrap_cnt_q;
    good_clr     = 1'b0;
    good_inc     = 1'b0;
    bad_clr      = 1'b0;
    bad_inc      = 1'b0;
    err_inc      = 1'b0;
    if (clr) begin
      state_d    = CHK_ACQ;
      locked_d   = 1'b0;
      exp_d      = '0;
      wrap_cnt_d = '0;
      good_clr   = 1'b1;
      bad_clr    = 1'b1;
    end else if (cnt_vld) begin
      // Always resync the expectation to the observed value.
      exp_d = cnt_val + 1'b1;
      case (state_q)
        CHK_ACQ: begin
          good_clr = 1'b1;
          good_inc = 1'b1;
          bad_clr  = 1'b1;
          if (LOCK_N == 1) begin
            state_d  = CHK_LOCK;
            locked_d = 1'b1;
          end else begin
            state_d = CHK_SYNC;
          end
        end
        CHK_SYNC: begin
          good_inc = 1'b1;
          if (!match) begin
            good_clr = 1'b1;
          end else if (32'(good_cnt) + 32'd1 >= LOCK_N) begin
            state_d  = CHK_LOCK;
            locked_d = 1'b1;
            bad_clr  = 1'b1;
          end
        end
        CHK_LOCK: begin
          if (match) begin
            bad_clr = 1'b1;
            if (cnt_val == '0) begin
              wrap_pulse_d = 1'b1;
              wrap_cnt_d   = wrap_cnt_q + 1'b1;
            end
          end else begin
            err_pulse_d = 1'b1;
            err_inc     = 1'b1;
            bad_inc     = 1'b1;
            if (32'(bad_cnt) + 32'd1 >= UNLOCK_N) begin
              state_d  = CHK_SYNC;
              locked_d = 1'b0;
              good_clr = 1'b1;
              good_inc = 1'b1;
              bad_inc  = 1'b0;
              bad_clr  = 1'b1;
            end
          end
        end
        default: state_d = CHK_ACQ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= CHK_ACQ;
      locked_q     <= 1'b0;
      exp_q        <= '0;
      wrap_pulse_q <= 1'b0;
      err_pulse_q  <= 1'b0;
      wrap_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      locked_q     <= locked_d;
      exp_q        <= exp_d;
      wrap_pulse_q <= wrap_pulse_d;
      err_pulse_q  <= err_pulse_d;
      wrap_cnt_q   <= wrap_cnt_d;
    end
  end

  cnt_chk_sat_ctr #(.WIDTH(GOOD_W)) u_good_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (good_clr),
    .inc   (good_inc),
    .cnt   (good_cnt)
  );

  cnt_chk_sat_ctr #(.WIDTH(BAD_W)) u_bad_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (bad_clr),
    .inc   (bad_inc),
    .cnt   (bad_cnt)
  );

  cnt_chk_sat_ctr #(.WIDTH(ERR_W)) u_err_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (err_inc),
    .cnt   (err_cnt)
  );

`ifdef CNT_CHK_STICKY_ERR_EN
  logic sticky_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         sticky_q <= 1'b0;
    else if (clr)       sticky_q <= 1'b0;
    else if (err_inc)   sticky_q <= 1'b1;
  end

  assign err_sticky = sticky_q;
`endif

  assign locked     = locked_q;
  assign exp_val    = exp_q;
  assign wrap_pulse = wrap_pulse_q;
  assign err_pulse  = err_pulse_q;
  assign wrap_cnt   = wrap_cnt_q;

endmodule

// File: tb/tb_cnt_seq_checker.sv
// Directed bench for cnt_seq_checker: default instance plus an ERR_W=2/UNLOCK_N=8 instance.
module tb_cnt_seq_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic       cnt_vld = 1'b0;
  logic [2:0] cnt_val = '0;

  logic       locked, wrap_pulse, err_pulse;
  logic [2:0] exp_val;
  logic [7:0] wrap_cnt, err_cnt;

  logic       locked2, wrap_pulse2, err_pulse2;
  logic [2:0] exp_val2;
  logic [7:0] wrap_cnt2;
  logic [1:0] err_cnt2;
`ifdef CNT_CHK_STICKY_ERR_EN
  logic       err_sticky, err_sticky2;
`endif

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  cnt_seq_checker #(.W(3), .WRAP_W(8), .ERR_W(8), .LOCK_N(4), .UNLOCK_N(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .cnt_vld    (cnt_vld),
    .cnt_val    (cnt_val),
`ifdef CNT_CHK_STICKY_ERR_EN
    .err_sticky (err_sticky),
`endif
    .locked     (locked),
    .exp_val    (exp_val),
    .wrap_pulse (wrap_pulse),
    .err_pulse  (err_pulse),
    .wrap_cnt   (wrap_cnt),
    .err_cnt    (err_cnt)
  );

  cnt_seq_checker #(.W(3), .WRAP_W(8), .ERR_W(2), .LOCK_N(4), .UNLOCK_N(8)) dut2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .cnt_vld    (cnt_vld),
    .cnt_val    (cnt_val),
`ifdef CNT_CHK_STICKY_ERR_EN
    .err_sticky (err_sticky2),
`endif
    .locked     (locked2),
    .exp_val    (exp_val2),
    .wrap_pulse (wrap_pulse2),
    .err_pulse  (err_pulse2),
    .wrap_cnt   (wrap_cnt2),
    .err_cnt    (err_cnt2)
  );

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Apply one cycle of stimulus and leave time just past the sampling edge.
  task automatic drive(input logic vld, input logic [2:0] v, input logic c = 1'b0);
    @(negedge clk);
    cnt_vld = vld;
    cnt_val = v;
    clr     = c;
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " locked"}, locked, 0);
    check({tag, " exp_val"}, exp_val, 0);
    check({tag, " wrap_pulse"}, wrap_pulse, 0);
    check({tag, " err_pulse"}, err_pulse, 0);
    check({tag, " wrap_cnt"}, wrap_cnt, 0);
    check({tag, " err_cnt"}, err_cnt, 0);
  endtask

  logic [2:0] e;

  initial begin
    #12 rst_n = 1'b1;
    #1;
    check_all_zero("reset");

    // 1: in-sequence stream locks after sample 3, wraps at 7->0.
    for (int v = 0; v < 8; v++) begin
      drive(1'b1, 3'(v));
      check($sformatf("t1 locked after %0d", v), locked, (v >= 3) ? 1 : 0);
      check($sformatf("t1 exp after %0d", v), exp_val, (v + 1) % 8);
    end
    check("t1 no wrap yet", wrap_cnt, 0);
    drive(1'b1, 3'd0);
    check("t1 wrap_pulse", wrap_pulse, 1);
    check("t1 wrap_cnt", wrap_cnt, 1);
    drive(1'b1, 3'd1);
    check("t1 wrap_pulse drop", wrap_pulse, 0);
    check("t1 wrap_cnt hold", wrap_cnt, 1);

    // 2: single mismatch while locked.
    drive(1'b1, 3'd2);
    drive(1'b1, 3'd3);
    drive(1'b1, 3'd5);
    check("t2 err_pulse", err_pulse, 1);
    check("t2 err_cnt", err_cnt, 1);
    check("t2 locked", locked, 1);
    drive(1'b1, 3'd6);
    check("t2 err_pulse drop", err_pulse, 0);
    check("t2 exp after 6", exp_val, 7);
    drive(1'b1, 3'd7);
    check("t2 still locked", locked, 1);

    // 3: two consecutive mismatches drop lock; three matches re-lock.
    drive(1'b1, 3'd0);
    check("t3 wrap_cnt", wrap_cnt, 2);
    drive(1'b1, 3'd2);
    check("t3 err_cnt first", err_cnt, 2);
    check("t3 locked first", locked, 1);
    drive(1'b1, 3'd6);
    check("t3 err_cnt second", err_cnt, 3);
    check("t3 unlocked", locked, 0);
    check("t3 exp", exp_val, 7);
    drive(1'b1, 3'd7);
    check("t3 relock 1", locked, 0);
    drive(1'b1, 3'd0);
    check("t3 relock 2", locked, 0);
    check("t3 no wrap in sync", wrap_pulse, 0);
    check("t3 wrap_cnt held", wrap_cnt, 2);
    drive(1'b1, 3'd1);
    check("t3 relocked", locked, 1);

    // 4: clr ignores the sample; gapped stream gives the same results.
    drive(1'b1, 3'd5, 1'b1);
    check_all_zero("t4 clr");
    for (int v = 0; v < 8; v++) begin
      drive(1'b1, 3'(v));
      drive(1'b0, 3'd6);
      check($sformatf("t4 locked gap %0d", v), locked, (v >= 3) ? 1 : 0);
      check($sformatf("t4 exp gap %0d", v), exp_val, (v + 1) % 8);
    end
    drive(1'b1, 3'd0);
    check("t4 wrap_pulse", wrap_pulse, 1);
    check("t4 wrap_cnt", wrap_cnt, 1);
    drive(1'b0, 3'd3);
    check("t4 wrap_pulse gap", wrap_pulse, 0);
    check("t4 err_cnt", err_cnt, 0);

    // 5: isolated mismatches saturate the 2-bit error counter of dut2.
    e = 3'd1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, e + 3'd2);
      check($sformatf("t5 err_pulse2 %0d", i), err_pulse2, 1);
      check($sformatf("t5 err_cnt2 %0d", i), err_cnt2, (i < 3) ? i + 1 : 3);
      drive(1'b1, e + 3'd3);
      e = e + 3'd4;
    end
    check("t5 locked2", locked2, 1);
    check("t5 err_cnt wide", err_cnt, 5);
    check("t5 locked", locked, 1);
`ifdef CNT_CHK_STICKY_ERR_EN
    check("t5 err_sticky2", err_sticky2, 1);
`endif

    // 6: async reset mid-lock, then clr while locked.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("t6 rst");
    check("t6 rst err_cnt2", err_cnt2, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int v = 0; v < 4; v++) drive(1'b1, 3'(v));
    check("t6 relock", locked, 1);
    drive(1'b1, 3'd4, 1'b1);
    check_all_zero("t6 clr");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
